brick_ctrl: RTL and testbench

BRICK_CTRL -- requirements
Module: brick_ctrl

---
 rtl/brick_ctrl.sv | 262 ++++++++++++++++++++++++++
 tb/tb_brick_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/brick_ctrl.sv
// Active-brick controller: spawn, move/rotate/gravity tries against an external
// collision checker, lock/hard-drop, board placement. Optional BRICK_CTRL_SHADOW_EN adds the landing-row search.
module brick_ctrl #(
  parameter int unsigned BOARD_W     = 10,
  parameter int unsigned BOARD_H     = 20,
  parameter int unsigned GRAVITY_DIV = 32,
  parameter int unsigned LOCK_TICKS  = 2,
  parameter int unsigned SPAWN_X     = 4,
  parameter int unsigned SPAWN_Y     = 18,
  localparam int unsigned XW = $clog2(BOARD_W),
  localparam int unsigned YW = $clog2(BOARD_H)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  input  logic [2:0]    next_type,
  input  logic          cmd_valid,
  input  logic [2:0]    cmd,
  output logic          cmd_ready,
  output logic [XW-1:0] try_x,
  output logic [YW-1:0] try_y,
  output logic [1:0]    try_dir,
  output logic [2:0]    try_type,
  input  logic          try_collided,
  output logic [XW-1:0] cur_x,
  output logic [YW-1:0] cur_y,
  output logic [1:0]    cur_dir,
  output logic [2:0]    cur_type,
  output logic          place_valid,
  input  logic          place_ready,
  output logic [YW-1:0] sh_probe_y,
  input  logic          sh_collided,
  output logic [YW-1:0] shadow_y,
  output logic          shadow_valid,
  output logic          game_over,
  output logic [3:0]    state
);

  localparam int unsigned GW = (GRAVITY_DIV > 1) ? $clog2(GRAVITY_DIV) : 1;
  localparam int unsigned LW = $clog2(LOCK_TICKS + 1);

  localparam logic [2:0] CMD_LEFT  = 3'd0;
  localparam logic [2:0] CMD_RIGHT = 3'd1;
  localparam logic [2:0] CMD_DOWN  = 3'd2;
  localparam logic [2:0] CMD_CW    = 3'd3;
  localparam logic [2:0] CMD_CCW   = 3'd4;
  localparam logic [2:0] CMD_HARD  = 3'd5;

  typedef enum logic [3:0] {
    S_SPAWN     = 4'd0,
    S_SPAWN_CHK = 4'd1,
    S_WAIT      = 4'd2,
    S_TRY       = 4'd3,
    S_HARD      = 4'd4,
    S_PLACE     = 4'd5,
    S_OVER      = 4'd6
  } state_t;

  typedef struct packed {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [1:0]    dir;
    logic [2:0]    typ;
  } brick_t;

  state_t        state_q, state_d;
  brick_t        cur_q, cur_d, try_q, try_d;
  logic          try_blk_q, try_blk_d;   // try forced collided (edge of board)
  logic          try_down_q, try_down_d; // try is a downward move that can lock
  logic [GW-1:0] grav_q, grav_d;
  logic          pend_q, pend_d;
  logic [LW-1:0] lock_q, lock_d, lock_inc;
  logic          collided;
  logic          cmd_ready_d, place_valid_d, game_over_d;

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    try_d      = try_q;
    try_blk_d  = try_blk_q;
    try_down_d = try_down_q;
    grav_d     = grav_q;
    pend_d     = pend_q;
    lock_d     = lock_q;
    lock_inc   = lock_q + LW'(1);
    collided   = try_collided | try_blk_q;

    case (state_q)
      S_SPAWN: begin
        cur_d.x    = XW'(SPAWN_X);
        cur_d.y    = YW'(SPAWN_Y);
        cur_d.dir  = 2'd0;
        cur_d.typ  = next_type;
        try_d      = cur_d;
        try_blk_d  = 1'b0;
        try_down_d = 1'b0;
        grav_d     = '0;
        pend_d     = 1'b0;
        lock_d     = '0;
        state_d    = S_SPAWN_CHK;
      end
      S_SPAWN_CHK: state_d = collided ? S_OVER : S_WAIT;
      S_WAIT: begin
        if (cmd_valid) begin
          try_d      = cur_q;
          try_blk_d  = 1'b0;
          try_down_d = 1'b0;
          state_d    = S_TRY;
          case (cmd)
            CMD_LEFT: begin
              if (cur_q.x == '0) try_blk_d = 1'b1;
              else               try_d.x   = cur_q.x - XW'(1);
            end
            CMD_RIGHT: try_d.x = cur_q.x + XW'(1);
            CMD_DOWN, CMD_HARD: begin
              try_down_d = (cmd == CMD_DOWN);
              if (cmd == CMD_HARD) state_d = S_HARD;
              if (cur_q.y == '0) try_blk_d = 1'b1;
              else               try_d.y   = cur_q.y - YW'(1);
            end
            CMD_CW:  try_d.dir = cur_q.dir + 2'd1;
            CMD_CCW: try_d.dir = cur_q.dir - 2'd1;
            default: state_d = S_WAIT;
          endcase
        end else if (pend_q) begin
          // deferred gravity drop, served on the first idle cycle
          pend_d     = 1'b0;
          try_d      = cur_q;
          try_down_d = 1'b1;
          try_blk_d  = (cur_q.y == '0);
          if (cur_q.y != '0) try_d.y = cur_q.y - YW'(1);
          state_d    = S_TRY;
        end
        if (tick) begin
          if (grav_q == GW'(GRAVITY_DIV - 1)) begin
            grav_d = '0;
            pend_d = 1'b1;
          end else begin
            grav_d = grav_q + GW'(1);
          end
        end
      end
      S_TRY: begin
        state_d = S_WAIT;
        if (!collided) begin
          cur_d  = try_q;
          lock_d = '0;
        end else if (try_down_q) begin
          lock_d = lock_inc;
          if (32'(lock_inc) >= LOCK_TICKS) state_d = S_PLACE;
        end
      end
      S_HARD: begin
        if (collided) begin
          state_d = S_PLACE;
        end else begin
          cur_d.y = try_q.y;
          if (try_q.y == '0) try_blk_d = 1'b1;
          else               try_d.y   = try_q.y - YW'(1);
        end
      end
      S_PLACE: if (place_valid && place_ready) state_d = S_SPAWN;
      S_OVER:  state_d = S_OVER;
      default: state_d = S_SPAWN;
    endcase

    cmd_ready_d   = (state_d == S_WAIT);
    place_valid_d = (state_d == S_PLACE);
    game_over_d   = (state_d == S_OVER);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_SPAWN;
      cur_q       <= '{x: XW'(SPAWN_X), y: YW'(SPAWN_Y), dir: 2'd0, typ: 3'd0};
      try_q       <= '{x: XW'(SPAWN_X), y: YW'(SPAWN_Y), dir: 2'd0, typ: 3'd0};
      try_blk_q   <= 1'b0;
      try_down_q  <= 1'b0;
      grav_q      <= '0;
      pend_q      <= 1'b0;
      lock_q      <= '0;
      cmd_ready   <= 1'b0;
      place_valid <= 1'b0;
      game_over   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      try_q       <= try_d;
      try_blk_q   <= try_blk_d;
      try_down_q  <= try_down_d;
      grav_q      <= grav_d;
      pend_q      <= pend_d;
      lock_q      <= lock_d;
      cmd_ready   <= cmd_ready_d;
      place_valid <= place_valid_d;
      game_over   <= game_over_d;
    end
  end

  assign state    = state_q;
  assign cur_x    = cur_q.x;
  assign cur_y    = cur_q.y;
  assign cur_dir  = cur_q.dir;
  assign cur_type = cur_q.typ;
  assign try_x    = try_q.x;
  assign try_y    = try_q.y;
  assign try_dir  = try_q.dir;
  assign try_type = try_q.typ;

`ifdef BRICK_CTRL_SHADOW_EN
  logic [YW-1:0] sh_y_q, sh_y_d, probe_d, shadow_y_d;
  logic          sh_busy_q, sh_busy_d, shadow_valid_d;

  // Landing-row search restarts whenever the active brick changes
  always_comb begin
    sh_y_d         = sh_y_q;
    probe_d        = sh_probe_y;
    shadow_y_d     = shadow_y;
    shadow_valid_d = shadow_valid;
    sh_busy_d      = sh_busy_q;
    if (state_q == S_SPAWN || cur_d != cur_q) begin
      sh_y_d         = cur_d.y;
      probe_d        = cur_d.y - YW'(1);
      sh_busy_d      = 1'b1;
      shadow_valid_d = 1'b0;
    end else if (sh_busy_q) begin
      if (sh_y_q == '0 || sh_collided) begin
        shadow_y_d     = sh_y_q;
        shadow_valid_d = 1'b1;
        sh_busy_d      = 1'b0;
      end else begin
        sh_y_d  = sh_y_q - YW'(1);
        probe_d = sh_y_q - YW'(2);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_y_q       <= YW'(SPAWN_Y);
      sh_probe_y   <= YW'(SPAWN_Y);
      shadow_y     <= YW'(SPAWN_Y);
      shadow_valid <= 1'b0;
      sh_busy_q    <= 1'b0;
    end else begin
      sh_y_q       <= sh_y_d;
      sh_probe_y   <= probe_d;
      shadow_y     <= shadow_y_d;
      shadow_valid <= shadow_valid_d;
      sh_busy_q    <= sh_busy_d;
    end
  end
`else
  logic sh_unused;
  assign sh_unused    = sh_collided;
  assign shadow_y     = cur_q.y;
  assign shadow_valid = 1'b0;
  assign sh_probe_y   = '0;
`endif

endmodule

// File: tb/tb_brick_ctrl.sv
// Directed bench for brick_ctrl: vector table of single moves plus hand-written
// gravity, lock, hard-drop, reset-abort, game-over and shadow sequences.
module tb_brick_ctrl;
  localparam int unsigned XW = 4;
  localparam int unsigned YW = 5;

  localparam int ST_SPAWN = 0, ST_SCHK = 1, ST_WAIT = 2, ST_TRY = 3,
                 ST_HARD = 4, ST_PLACE = 5, ST_OVER = 6;

  logic          clk = 1'b0;
  logic          rst, tick, cmd_valid, place_ready;
  logic [2:0]    next_type, cmd;
  logic          cmd_ready, try_collided, place_valid, sh_collided;
  logic          shadow_valid, game_over;
  logic [XW-1:0] try_x, cur_x;
  logic [YW-1:0] try_y, cur_y, sh_probe_y, shadow_y;
  logic [1:0]    try_dir, cur_dir;
  logic [2:0]    try_type, cur_type;
  logic [3:0]    state;

  // Board model: everything below floor_y is occupied; spawn_block jams spawn
  logic [YW-1:0] floor_y;
  logic          spawn_block;
  assign try_collided = spawn_block | (try_y < floor_y);
  assign sh_collided  = (sh_probe_y < floor_y);

  brick_ctrl #(.GRAVITY_DIV(4)) dut (
    .clk(clk), .rst(rst), .tick(tick), .next_type(next_type),
    .cmd_valid(cmd_valid), .cmd(cmd), .cmd_ready(cmd_ready),
    .try_x(try_x), .try_y(try_y), .try_dir(try_dir), .try_type(try_type),
    .try_collided(try_collided),
    .cur_x(cur_x), .cur_y(cur_y), .cur_dir(cur_dir), .cur_type(cur_type),
    .place_valid(place_valid), .place_ready(place_ready),
    .sh_probe_y(sh_probe_y), .sh_collided(sh_collided),
    .shadow_y(shadow_y), .shadow_valid(shadow_valid),
    .game_over(game_over), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] c;
    int         ex;
    int         ey;
    int         ed;
    int         lat;
  } vec_t;

  vec_t vecs [12];
  int   checks = 0;
  int   failures = 0;
  int   n;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cmd(input logic [2:0] c);
    cmd_valid = 1'b1;
    cmd       = c;
    step();
    cmd_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; cmd_valid = 1'b0; cmd = 3'd0; place_ready = 1'b0;
    next_type = 3'd3; floor_y = '0; spawn_block = 1'b0;

    // start (4,18,0): four LEFTs to the wall, one blocked, rotations, right, down, no-op
    vecs[0]  = '{3'd0, 3, 18, 0, 2};
    vecs[1]  = '{3'd0, 2, 18, 0, 2};
    vecs[2]  = '{3'd0, 1, 18, 0, 2};
    vecs[3]  = '{3'd0, 0, 18, 0, 2};
    vecs[4]  = '{3'd0, 0, 18, 0, 2};
    vecs[5]  = '{3'd4, 0, 18, 3, 2};
    vecs[6]  = '{3'd3, 0, 18, 0, 2};
    vecs[7]  = '{3'd1, 1, 18, 0, 2};
    vecs[8]  = '{3'd2, 1, 17, 0, 2};
    vecs[9]  = '{3'd3, 1, 17, 1, 2};
    vecs[10] = '{3'd6, 1, 17, 1, 1};
    vecs[11] = '{3'd3, 1, 17, 2, 2};

    repeat (2) step();
    chk("rst_state", int'(state), ST_SPAWN);
    chk("rst_cmd_ready", int'(cmd_ready), 0);
    chk("rst_place_valid", int'(place_valid), 0);
    chk("rst_game_over", int'(game_over), 0);
    chk("rst_shadow_valid", int'(shadow_valid), 0);
    chk("rst_shadow_y", int'(shadow_y), 18);
    chk("rst_cur_x", int'(cur_x), 4);
    chk("rst_cur_y", int'(cur_y), 18);
    chk("rst_cur_dir", int'(cur_dir), 0);
    chk("rst_cur_type", int'(cur_type), 0);
    chk("rst_try_x", int'(try_x), 4);
    chk("rst_try_y", int'(try_y), 18);
`ifdef BRICK_CTRL_SHADOW_EN
    chk("rst_sh_probe_y", int'(sh_probe_y), 18);
`endif

    rst = 1'b0;
    step();
    chk("spawn_chk_state", int'(state), ST_SCHK);
    step();
    chk("wait_state", int'(state), ST_WAIT);
    chk("spawn_cur_x", int'(cur_x), 4);
    chk("spawn_cur_y", int'(cur_y), 18);
    chk("spawn_cur_dir", int'(cur_dir), 0);
    chk("spawn_cur_type", int'(cur_type), 3);
    chk("spawn_cmd_ready", int'(cmd_ready), 1);

    for (int i = 0; i < 12; i++) begin
      do_cmd(vecs[i].c);
      n = 1;
      while (!cmd_ready && n < 6) begin
        step();
        n++;
      end
      chk($sformatf("vec%0d_latency", i), n, vecs[i].lat);
      chk($sformatf("vec%0d_x", i), int'(cur_x), vecs[i].ex);
      chk($sformatf("vec%0d_y", i), int'(cur_y), vecs[i].ey);
      chk($sformatf("vec%0d_dir", i), int'(cur_dir), vecs[i].ed);
`ifndef BRICK_CTRL_SHADOW_EN
      chk($sformatf("vec%0d_shadow_y", i), int'(shadow_y), vecs[i].ey);
      chk($sformatf("vec%0d_shadow_valid", i), int'(shadow_valid), 0);
      chk($sformatf("vec%0d_sh_probe_y", i), int'(sh_probe_y), 0);
`endif
    end

    // Gravity: four ticks, then drop on the next idle cycle
    for (int t = 0; t < 4; t++) begin
      tick = 1'b1; step(); tick = 1'b0;
      chk($sformatf("grav_tick%0d_y", t), int'(cur_y), 17);
    end
    step();
    chk("grav_try_state", int'(state), ST_TRY);
    step();
    chk("grav_drop_y", int'(cur_y), 16);

    // Command on the wrapping tick wins; drop follows afterwards
    for (int t = 0; t < 3; t++) begin
      tick = 1'b1; step(); tick = 1'b0;
    end
    tick = 1'b1; cmd_valid = 1'b1; cmd = 3'd3;
    step();
    tick = 1'b0; cmd_valid = 1'b0;
    step();
    chk("grav_prio_dir", int'(cur_dir), 3);
    chk("grav_prio_y_held", int'(cur_y), 16);
    step();
    chk("grav_prio_try_state", int'(state), ST_TRY);
    step();
    chk("grav_prio_drop_y", int'(cur_y), 15);
    chk("grav_prio_state", int'(state), ST_WAIT);

    // Lock: two blocked DOWNs place the brick
    floor_y = 5'd15;
    do_cmd(3'd2); step();
    chk("lock1_state", int'(state), ST_WAIT);
    chk("lock1_y", int'(cur_y), 15);
    chk("lock1_place_valid", int'(place_valid), 0);
    do_cmd(3'd2); step();
    chk("lock2_state", int'(state), ST_PLACE);
    chk("lock2_place_valid", int'(place_valid), 1);
    tick = 1'b1; step(); tick = 1'b0;
    chk("lock_hold_place_valid", int'(place_valid), 1);
    chk("lock_hold_y", int'(cur_y), 15);
    place_ready = 1'b1; next_type = 3'd5;
    step();
    place_ready = 1'b0;
    chk("lock_to_spawn", int'(state), ST_SPAWN);
    chk("lock_pv_drop", int'(place_valid), 0);
    repeat (2) step();
    chk("respawn_state", int'(state), ST_WAIT);
    chk("respawn_type", int'(cur_type), 5);
    chk("respawn_y", int'(cur_y), 18);
    chk("respawn_dir", int'(cur_dir), 0);

    // Hard drop from 18 onto floor 5: one row per cycle
    floor_y = 5'd5;
    do_cmd(3'd5);
    chk("hard_state", int'(state), ST_HARD);
    repeat (13) step();
    chk("hard_13_y", int'(cur_y), 5);
    chk("hard_13_state", int'(state), ST_HARD);
    step();
    chk("hard_place_state", int'(state), ST_PLACE);
    chk("hard_place_valid", int'(place_valid), 1);
    for (int d = 0; d < 3; d++) begin
      step();
      chk($sformatf("hard_hold%0d_y", d), int'(cur_y), 5);
      chk($sformatf("hard_hold%0d_x", d), int'(cur_x), 4);
      chk($sformatf("hard_hold%0d_pv", d), int'(place_valid), 1);
    end
    place_ready = 1'b1; step(); place_ready = 1'b0;
    chk("hard_spawn", int'(state), ST_SPAWN);
    repeat (2) step();
    chk("hard_respawn_y", int'(cur_y), 18);

    // Reset in the middle of a hard drop
    do_cmd(3'd5);
    repeat (3) step();
    rst = 1'b1; #1;
    chk("abort_state", int'(state), ST_SPAWN);
    chk("abort_place_valid", int'(place_valid), 0);
    chk("abort_cur_y", int'(cur_y), 18);
    step();

    // Blocked spawn: game over, commands ignored until reset
    spawn_block = 1'b1;
    rst = 1'b0;
    repeat (2) step();
    chk("over_state", int'(state), ST_OVER);
    chk("over_game_over", int'(game_over), 1);
    chk("over_cmd_ready", int'(cmd_ready), 0);
    cmd_valid = 1'b1; cmd = 3'd0;
    repeat (3) step();
    cmd_valid = 1'b0;
    chk("over_cur_x", int'(cur_x), 4);
    chk("over_hold_state", int'(state), ST_OVER);
    chk("over_place_valid", int'(place_valid), 0);
    rst = 1'b1; step();
    chk("over_cleared", int'(game_over), 0);
    spawn_block = 1'b0;

`ifdef BRICK_CTRL_SHADOW_EN
    // Landing-row search with the floor at row 2
    floor_y = 5'd2;
    rst = 1'b0;
    n = 0;
    while (!shadow_valid && n < 30) begin
      step();
      n++;
    end
    chk("sh_spawn_latency_ok", int'(n <= 18), 1);
    chk("sh_spawn_y", int'(shadow_y), 2);
    chk("sh_spawn_valid", int'(shadow_valid), 1);
    do_cmd(3'd0); step();
    chk("sh_move_x", int'(cur_x), 3);
    chk("sh_move_invalid", int'(shadow_valid), 0);
    n = 0;
    while (!shadow_valid && n < 30) begin
      step();
      n++;
    end
    chk("sh_move_valid", int'(shadow_valid), 1);
    chk("sh_move_y", int'(shadow_y), 2);
`else
    rst = 1'b0;
    repeat (3) step();
    chk("nosh_shadow_y", int'(shadow_y), int'(cur_y));
    chk("nosh_shadow_valid", int'(shadow_valid), 0);
    chk("nosh_probe", int'(sh_probe_y), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
